// File: rtl/ps2_kbd_event_fifo.sv
// PS/2 set-2 scancode decoder feeding a first-word-fall-through key event FIFO.
// Event format is {ext, rel, code[7:0]}; overflow and receive errors are tracked for software.
module ps2_kbd_event_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic [7:0]    ps2_code_i,
  input  logic          ps2_strobe_i,
  input  logic          ps2_err_i,
  input  logic          rd_i,
  input  logic          flush_i,
  input  logic          clr_i,
  output logic [9:0]    event_o,
  output logic          valid_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic [7:0]    err_cnt_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  state_e        state_q, state_d;
  logic [2:0]    skip_q, skip_d;
  logic          push;
  logic [9:0]    push_data;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q;
  logic          overflow_q;
  logic [7:0]    err_cnt_q;

  logic          full, pop_ok, push_ok, drop;

  // Decoder next state: prefixes accumulate until a terminating byte produces one event
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    push      = 1'b0;
    push_data = '0;
    if (ps2_err_i) begin
      // A corrupted byte invalidates any partially received prefix
      state_d = StIdle;
      skip_d  = '0;
    end else if (ps2_strobe_i) begin
      case (state_q)
        StIdle: begin
          if (ps2_code_i == 8'hE0) begin
            state_d = StExt;
          end else if (ps2_code_i == 8'hF0) begin
            state_d = StBrk;
          end else if (ps2_code_i == 8'hE1) begin
            state_d = StPause;
            skip_d  = 3'd7;
          end else begin
            push      = 1'b1;
            push_data = {2'b00, ps2_code_i};
          end
        end
        StExt: begin
          if (ps2_code_i == 8'hF0) begin
            state_d = StExtBrk;
          end else if (ps2_code_i != 8'hE0) begin
            push      = 1'b1;
            push_data = {2'b10, ps2_code_i};
            state_d   = StIdle;
          end
        end
        StBrk: begin
          if (ps2_code_i == 8'hE0) begin
            state_d = StExtBrk;
          end else if (ps2_code_i != 8'hF0) begin
            push      = 1'b1;
            push_data = {2'b01, ps2_code_i};
            state_d   = StIdle;
          end
        end
        StExtBrk: begin
          if ((ps2_code_i != 8'hE0) && (ps2_code_i != 8'hF0)) begin
            push      = 1'b1;
            push_data = {2'b11, ps2_code_i};
            state_d   = StIdle;
          end
        end
        StPause: begin
          // The 8-byte Pause sequence collapses to a single extended E1 event
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            push      = 1'b1;
            push_data = {2'b10, 8'hE1};
            state_d   = StIdle;
            skip_d    = '0;
          end
        end
        default: begin
          state_d = StIdle;
          skip_d  = '0;
        end
      endcase
    end
  end

  // Decoder state register; flush also abandons any prefix in progress
  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      state_q <= StIdle;
      skip_q  <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // FIFO handshake: a full FIFO still accepts a push when the same cycle pops
  always_comb begin
    full    = (count_q == FullCnt);
    pop_ok  = rd_i && valid_q && !flush_i;
    push_ok = push && !flush_i && (!full || pop_ok);
    drop    = push && !flush_i && full && !pop_ok;
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage array; no reset needed since the pointers define what is live
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      valid_q <= (count_d != '0);
    end
  end

  // Sticky status; a new overflow or error beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset_i) begin
      overflow_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (drop) begin
        overflow_q <= 1'b1;
      end else if (clr_i) begin
        overflow_q <= 1'b0;
      end
      if (ps2_err_i) begin
        if (clr_i) begin
          err_cnt_q <= 8'd1;
        end else if (err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else if (clr_i) begin
        err_cnt_q <= '0;
      end
    end
  end

  assign event_o    = valid_q ? mem[rd_ptr_q] : '0;
  assign valid_o    = valid_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
